// File: rtl/rs_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_scheduler_pkg
//  Description : Shared defines and helpers for the reservation-station
//                scheduler: slot count, ROB tag range, and small
//                combinational helpers (free-slot encoder, popcount, CDB
//                bypass of dispatched tags).
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef RS_DEFINES_SVH
`define RS_DEFINES_SVH
`define RS_SIZE   16
`define ROB_W     4
`define ROB_RANGE 3:0
`endif

package rs_scheduler_pkg;

    localparam int c_RS_SIZE = `RS_SIZE;
    localparam int c_IDX_W   = $clog2(`RS_SIZE);
    localparam int c_CNT_W   = $clog2(`RS_SIZE) + 1;

    // Lowest-index zero bit of v; returns 0 when v is all ones.
    function automatic logic [c_IDX_W-1:0] first_zero(input logic [c_RS_SIZE-1:0] v);
        logic [c_IDX_W-1:0] idx;
        idx = '0;
        for (int i = c_RS_SIZE - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = c_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [c_CNT_W-1:0] popcount(input logic [c_RS_SIZE-1:0] v);
        logic [c_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < c_RS_SIZE; i++) begin
            if (v[i]) begin
                n = n + c_CNT_W'(1);
            end
        end
        return n;
    endfunction

    // A source tag that is being broadcast in the dispatch cycle is already
    // resolved, so it is stored as "no dependency".
    function automatic logic [`ROB_RANGE] bypass_tag(
        input logic [`ROB_RANGE] tag,
        input logic              cdb_valid,
        input logic [`ROB_RANGE] cdb_tag
    );
        if (cdb_valid && (cdb_tag != '0) && (tag == cdb_tag)) begin
            return '0;
        end
        return tag;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_scheduler_age.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_matrix
//  Description : Age matrix for the reservation station plus oldest-ready
//                selection. r_older[i][j]=1 means slot i is older than j.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_alloc_en/_idx   - slot being allocated this edge
//                i_ready           - per-slot ready vector
//                o_sel_onehot/_idx - oldest ready slot
//                o_any_ready       - at least one slot ready
//  Revision    : 1.0 - initial release
// ============================================================================

module rs_age_matrix
    import rs_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_alloc_en,
    input  logic [c_IDX_W-1:0]   i_alloc_idx,
    input  logic [c_RS_SIZE-1:0] i_ready,
    output logic [c_RS_SIZE-1:0] o_sel_onehot,
    output logic [c_IDX_W-1:0]   o_sel_idx,
    output logic                 o_any_ready
);

    logic [c_RS_SIZE-1:0] r_older [c_RS_SIZE];
    logic                 w_blocked;

    // A new allocation is younger than everything: its row is cleared and
    // every other slot becomes older than it. Relations between slots that
    // are both busy are therefore always consistent, so no flush clear is
    // needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < c_RS_SIZE; j++) begin
                r_older[j] <= '0;
            end
        end else if (i_alloc_en) begin
            for (int j = 0; j < c_RS_SIZE; j++) begin
                if (c_IDX_W'(j) == i_alloc_idx) begin
                    r_older[j] <= '0;
                end else begin
                    r_older[j][i_alloc_idx] <= 1'b1;
                end
            end
        end
    end

    // A ready slot is selected when no other ready slot is older than it.
    always_comb begin
        o_sel_onehot = '0;
        w_blocked    = 1'b0;
        for (int i = 0; i < c_RS_SIZE; i++) begin
            w_blocked = 1'b0;
            for (int j = 0; j < c_RS_SIZE; j++) begin
                if ((j != i) && i_ready[j] && r_older[j][i]) begin
                    w_blocked = 1'b1;
                end
            end
            o_sel_onehot[i] = i_ready[i] && !w_blocked;
        end
    end

    always_comb begin
        o_sel_idx = '0;
        for (int i = 0; i < c_RS_SIZE; i++) begin
            if (o_sel_onehot[i]) begin
                o_sel_idx = o_sel_idx | c_IDX_W'(i);
            end
        end
    end

    assign o_any_ready = |i_ready;

endmodule

`default_nettype wire

// File: rtl/rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rs_scheduler
//  Description : Sequencing controller for a 16-entry reservation station.
//                Tracks busy/pending and Qj/Qk tags per slot, allocates the
//                lowest free slot, wakes entries from CDB broadcasts and
//                issues the oldest ready entry through a valid/ready port.
//  Ports       : clk_in, rst_in, rdy_in, flush - clock, sync reset, global
//                                                enable, flush
//                disp_*  - dispatch request/slot/handshake
//                cdb_*   - result broadcast
//                iss_*   - registered issue request, FU ready
//                count, full, one_left - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================

module rs_scheduler
    import rs_scheduler_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  disp_valid,
    input  logic [`ROB_RANGE]     disp_qj,
    input  logic [`ROB_RANGE]     disp_qk,
    output logic                  disp_ready,
    output logic [c_IDX_W-1:0]    disp_slot,
    input  logic                  cdb_valid,
    input  logic [`ROB_RANGE]     cdb_tag,
    output logic                  iss_valid,
    output logic [c_IDX_W-1:0]    iss_slot,
    input  logic                  iss_ready,
    output logic [c_CNT_W-1:0]    count,
    output logic                  full,
    output logic                  one_left
);

    logic [c_RS_SIZE-1:0] r_busy;
    logic [c_RS_SIZE-1:0] r_pending;
    logic [`ROB_RANGE]    r_qj [c_RS_SIZE];
    logic [`ROB_RANGE]    r_qk [c_RS_SIZE];
    logic                 r_iss_valid;
    logic [c_IDX_W-1:0]   r_iss_slot;

    logic [c_RS_SIZE-1:0] w_ready;
    logic [c_RS_SIZE-1:0] w_sel_onehot;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic                 w_any_ready;
    logic                 w_wake;
    logic                 w_fire;
    logic                 w_iss_load;
    logic                 w_release;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < c_RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] && !r_pending[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
        end
    end

    assign count      = popcount(r_busy);
    assign full       = (count == c_CNT_W'(c_RS_SIZE));
    assign one_left   = (count == c_CNT_W'(c_RS_SIZE - 1));
    assign disp_slot  = first_zero(r_busy);
    assign disp_ready = !rst_in && !flush && !full;

    assign w_wake     = cdb_valid && (cdb_tag != '0);
    assign w_fire     = disp_valid && disp_ready && rdy_in;
    // Flush wins over issue: neither the load nor the release happens.
    assign w_iss_load = rdy_in && !flush && (!r_iss_valid || iss_ready);
    assign w_release  = rdy_in && !flush && r_iss_valid && iss_ready;

    assign iss_valid  = r_iss_valid;
    assign iss_slot   = r_iss_slot;

    rs_age_matrix u_age (
        .clk          (clk_in),
        .rst          (rst_in),
        .i_alloc_en   (w_fire),
        .i_alloc_idx  (disp_slot),
        .i_ready      (w_ready),
        .o_sel_onehot (w_sel_onehot),
        .o_sel_idx    (w_sel_idx),
        .o_any_ready  (w_any_ready)
    );

    // Slot state. An allocated slot is free, so it can never be the selected
    // or released slot in the same cycle; a released slot is pending, so it
    // is never reselected.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy    <= '0;
            r_pending <= '0;
            for (int i = 0; i < c_RS_SIZE; i++) begin
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                r_busy    <= '0;
                r_pending <= '0;
            end else begin
                for (int i = 0; i < c_RS_SIZE; i++) begin
                    if (w_wake && r_busy[i] && (r_qj[i] == cdb_tag)) begin
                        r_qj[i] <= '0;
                    end
                    if (w_wake && r_busy[i] && (r_qk[i] == cdb_tag)) begin
                        r_qk[i] <= '0;
                    end
                    if (w_fire && (disp_slot == c_IDX_W'(i))) begin
                        r_busy[i]    <= 1'b1;
                        r_pending[i] <= 1'b0;
                        r_qj[i]      <= bypass_tag(disp_qj, cdb_valid, cdb_tag);
                        r_qk[i]      <= bypass_tag(disp_qk, cdb_valid, cdb_tag);
                    end
                    if (w_iss_load && w_sel_onehot[i]) begin
                        r_pending[i] <= 1'b1;
                    end
                    if (w_release && (r_iss_slot == c_IDX_W'(i))) begin
                        r_busy[i]    <= 1'b0;
                        r_pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Issue register: holds while the FU stalls, reloads otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_iss_valid <= 1'b0;
            r_iss_slot  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_iss_valid <= 1'b0;
            end else if (w_iss_load) begin
                r_iss_valid <= w_any_ready;
                if (w_any_ready) begin
                    r_iss_slot <= w_sel_idx;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_scheduler
//  Description : Directed self-checking bench for rs_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_rs_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic       flush;
    logic       disp_valid;
    logic [3:0] disp_qj;
    logic [3:0] disp_qk;
    logic       disp_ready;
    logic [3:0] disp_slot;
    logic       cdb_valid;
    logic [3:0] cdb_tag;
    logic       iss_valid;
    logic [3:0] iss_slot;
    logic       iss_ready;
    logic [4:0] count;
    logic       full;
    logic       one_left;

    int n_checks = 0;
    int n_errors = 0;

    rs_scheduler dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_qj    (disp_qj),
        .disp_qk    (disp_qk),
        .disp_ready (disp_ready),
        .disp_slot  (disp_slot),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .iss_valid  (iss_valid),
        .iss_slot   (iss_slot),
        .iss_ready  (iss_ready),
        .count      (count),
        .full       (full),
        .one_left   (one_left)
    );

    always #5 clk_in = ~clk_in;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_qj = '0; disp_qk = '0;
        cdb_valid = 1'b0; cdb_tag = '0; iss_ready = 1'b0;
        tick(); tick();
        n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL reset_disp_ready: got %b expected 0", disp_ready); end
        n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iss_valid: got %b expected 0", iss_valid); end
        n_checks++; if (iss_slot !== 4'd0) begin n_errors++; $display("FAIL reset_iss_slot: got %0d expected 0", iss_slot); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (full !== 1'b0 || one_left !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got full=%b one_left=%b expected 0 0", full, one_left); end
        rst_in = 1'b0;
        #1;
        n_checks++; if (disp_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_disp_ready: got %b expected 1", disp_ready); end
    endtask

    task automatic test_basic_issue();
        iss_ready = 1'b1;
        disp_valid = 1'b1; disp_qj = 4'd0; disp_qk = 4'd0;
        #1;
        n_checks++; if (disp_slot !== 4'd0) begin n_errors++; $display("FAIL basic_disp_slot: got %0d expected 0", disp_slot); end
        tick();
        disp_valid = 1'b0;
        n_checks++; if (count !== 5'd1 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL basic_after_disp: got count=%0d iss_valid=%b expected 1 0", count, iss_valid); end
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd0) begin n_errors++; $display("FAIL basic_issue: got valid=%b slot=%0d expected 1 0", iss_valid, iss_slot); end
        n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL basic_pending_count: got %0d expected 1", count); end
        tick();
        n_checks++; if (count !== 5'd0 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL basic_release: got count=%0d iss_valid=%b expected 0 0", count, iss_valid); end
    endtask

    task automatic test_age_order();
        iss_ready = 1'b1;
        disp_valid = 1'b1; disp_qj = 4'd5; disp_qk = 4'd0;
        tick();                       // A -> slot 0, waits on tag 5
        disp_qj = 4'd0;
        tick();                       // B -> slot 1
        tick();                       // C -> slot 2, B loaded
        disp_valid = 1'b0;
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd1) begin n_errors++; $display("FAIL age_first_B: got valid=%b slot=%0d expected 1 1", iss_valid, iss_slot); end
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd2) begin n_errors++; $display("FAIL age_second_C: got valid=%b slot=%0d expected 1 2", iss_valid, iss_slot); end
        n_checks++; if (count !== 5'd2) begin n_errors++; $display("FAIL age_count: got %0d expected 2", count); end
        cdb_valid = 1'b1; cdb_tag = 4'd5;
        tick();                       // C accepted, A woken at this edge
        cdb_valid = 1'b0; cdb_tag = 4'd0;
        n_checks++; if (iss_valid !== 1'b0 || count !== 5'd1) begin n_errors++; $display("FAIL age_wake_gap: got valid=%b count=%0d expected 0 1", iss_valid, count); end
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd0) begin n_errors++; $display("FAIL age_third_A: got valid=%b slot=%0d expected 1 0", iss_valid, iss_slot); end
        tick();
        n_checks++; if (count !== 5'd0 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL age_drain: got count=%0d valid=%b expected 0 0", count, iss_valid); end
    endtask

    task automatic test_bypass();
        iss_ready = 1'b1;
        disp_valid = 1'b1; disp_qj = 4'd3; disp_qk = 4'd3;
        cdb_valid = 1'b1; cdb_tag = 4'd3;
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = 4'd0;
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd0) begin n_errors++; $display("FAIL bypass_issue: got valid=%b slot=%0d expected 1 0", iss_valid, iss_slot); end
        tick();
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL bypass_release: got %0d expected 0", count); end
        // Tag 0 broadcast must not resolve anything.
        disp_valid = 1'b1; disp_qj = 4'd3; disp_qk = 4'd0;
        cdb_valid = 1'b1; cdb_tag = 4'd0;
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (iss_valid !== 1'b0 || count !== 5'd1) begin n_errors++; $display("FAIL bypass_tag0: got valid=%b count=%0d expected 0 1", iss_valid, count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL bypass_cleanup: got %0d expected 0", count); end
    endtask

    task automatic test_full();
        iss_ready = 1'b0;
        disp_valid = 1'b1; disp_qj = 4'd7; disp_qk = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                n_checks++; if (count !== 5'd15 || one_left !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL full_at15: got count=%0d one_left=%b full=%b expected 15 1 0", count, one_left, full); end
                n_checks++; if (disp_slot !== 4'd15 || disp_ready !== 1'b1) begin n_errors++; $display("FAIL full_slot15: got slot=%0d ready=%b expected 15 1", disp_slot, disp_ready); end
            end
            tick();
        end
        n_checks++; if (count !== 5'd16 || full !== 1'b1 || one_left !== 1'b0 || disp_ready !== 1'b0) begin n_errors++; $display("FAIL full_at16: got count=%0d full=%b one_left=%b ready=%b expected 16 1 0 0", count, full, one_left, disp_ready); end
        tick();
        disp_valid = 1'b0;
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL full_no_overflow: got %0d expected 16", count); end
        cdb_valid = 1'b1; cdb_tag = 4'd7;
        tick();
        cdb_valid = 1'b0; cdb_tag = 4'd0;
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd0) begin n_errors++; $display("FAIL full_oldest: got valid=%b slot=%0d expected 1 0", iss_valid, iss_slot); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd0 || count !== 5'd16) begin n_errors++; $display("FAIL full_stall_hold: got valid=%b slot=%0d count=%0d expected 1 0 16", iss_valid, iss_slot, count); end
        end
        iss_ready = 1'b1;
        #1;
        n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL full_accept_same_cycle: got %b expected 0", disp_ready); end
        tick();
        n_checks++; if (count !== 5'd15 || disp_ready !== 1'b1 || disp_slot !== 4'd0) begin n_errors++; $display("FAIL full_freed: got count=%0d ready=%b slot=%0d expected 15 1 0", count, disp_ready, disp_slot); end
        for (int k = 1; k < 16; k++) begin
            n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'(k)) begin n_errors++; $display("FAIL full_stream: got valid=%b slot=%0d expected 1 %0d", iss_valid, iss_slot, k); end
            tick();
        end
        n_checks++; if (count !== 5'd0 || iss_valid !== 1'b0) begin n_errors++; $display("FAIL full_drained: got count=%0d valid=%b expected 0 0", count, iss_valid); end
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        disp_valid = 1'b1; disp_qj = 4'd0; disp_qk = 4'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        n_checks++; if (count !== 5'd8 || iss_valid !== 1'b1 || iss_slot !== 4'd0) begin n_errors++; $display("FAIL flush_setup: got count=%0d valid=%b slot=%0d expected 8 1 0", count, iss_valid, iss_slot); end
        flush = 1'b1;
        #1;
        n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL flush_disp_ready: got %b expected 0", disp_ready); end
        tick();
        flush = 1'b0; disp_valid = 1'b0;
        #1;
        n_checks++; if (count !== 5'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin n_errors++; $display("FAIL flush_result: got count=%0d valid=%b ready=%b expected 0 0 1", count, iss_valid, disp_ready); end
    endtask

    task automatic test_rdy_hold();
        iss_ready = 1'b0;
        disp_valid = 1'b1; disp_qj = 4'd9; disp_qk = 4'd0;
        tick();                       // X -> slot 0, waits on 9
        disp_qj = 4'd0;
        tick();                       // Y -> slot 1
        disp_valid = 1'b0;
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd1 || count !== 5'd2) begin n_errors++; $display("FAIL hold_setup: got valid=%b slot=%0d count=%0d expected 1 1 2", iss_valid, iss_slot, count); end
        rdy_in = 1'b0; disp_valid = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd9; iss_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd1 || count !== 5'd2) begin n_errors++; $display("FAIL hold_frozen: got valid=%b slot=%0d count=%0d expected 1 1 2", iss_valid, iss_slot, count); end
        end
        rdy_in = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = 4'd0;
        tick();                       // Y accepted; X still waiting
        n_checks++; if (iss_valid !== 1'b0 || count !== 5'd1) begin n_errors++; $display("FAIL hold_resume: got valid=%b count=%0d expected 0 1", iss_valid, count); end
        cdb_valid = 1'b1; cdb_tag = 4'd9;
        tick();
        cdb_valid = 1'b0; cdb_tag = 4'd0;
        tick();
        n_checks++; if (iss_valid !== 1'b1 || iss_slot !== 4'd0) begin n_errors++; $display("FAIL hold_wake_X: got valid=%b slot=%0d expected 1 0", iss_valid, iss_slot); end
        tick();
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL hold_drain: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_age_order();
        test_bypass();
        test_full();
        test_flush();
        test_rdy_hold();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
